// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: runs loads/stores as req/ack bus transactions, stalls the
// pipeline until they finish, and registers the MEM/WB write-back fields.
module mem_access_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead_mem,
   input  logic        MemWrite_mem,
   input  logic [1:0]  MemtoReg_mem,
   input  logic        RegWrite_mem,
   input  logic [4:0]  RegWriteAddr_mem,
   input  logic [31:0] ALUResult_mem,
   input  logic [31:0] MemWriteData_mem,
   input  logic [31:0] PC_4_mem,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        stall,
   output logic        RegWrite_wb,
   output logic [4:0]  RegWriteAddr_wb,
   output logic [31:0] WriteData_wb,
   output logic        mem_fault
);

   localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic access;
   logic misaligned;

   assign access     = MemRead_mem | MemWrite_mem;
   assign misaligned = (ALUResult_mem[1:0] != 2'b00);

   // Stall is combinational so the access is held in EX/MEM from its very first cycle.
   always_comb begin
      stall = 1'b0;
      if (!reset)
         stall = ((state == IDLE) && access && !misaligned) || (state == WAIT);
   end

   function automatic logic [31:0] wb_sel(input logic [1:0]  sel,
                                          input logic [31:0] alu,
                                          input logic [31:0] mem,
                                          input logic [31:0] pc4);
      case (sel)
         2'b01:   return mem;
         2'b10:   return pc4;
         default: return alu;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         rdata_q         <= '0;
         err_q           <= 1'b0;
         bus_req         <= 1'b0;
         bus_we          <= 1'b0;
         bus_addr        <= '0;
         bus_wdata       <= '0;
         RegWrite_wb     <= 1'b0;
         RegWriteAddr_wb <= '0;
         WriteData_wb    <= '0;
         mem_fault       <= 1'b0;
      end else begin
         mem_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (access && !misaligned) begin
                  bus_addr        <= ALUResult_mem;
                  bus_wdata       <= MemWriteData_mem;
                  bus_we          <= MemWrite_mem;
                  bus_req         <= 1'b1;
                  wait_cnt        <= '0;
                  rdata_q         <= '0;
                  err_q           <= 1'b0;
                  RegWrite_wb     <= 1'b0;
                  RegWriteAddr_wb <= '0;
                  WriteData_wb    <= '0;
                  state           <= WAIT;
               end else if (access) begin
                  // Misaligned: no bus cycle, the instruction retires without a register write.
                  RegWrite_wb     <= 1'b0;
                  RegWriteAddr_wb <= RegWriteAddr_mem;
                  WriteData_wb    <= wb_sel(MemtoReg_mem, ALUResult_mem, 32'h0, PC_4_mem);
                  mem_fault       <= 1'b1;
               end else begin
                  RegWrite_wb     <= RegWrite_mem;
                  RegWriteAddr_wb <= RegWriteAddr_mem;
                  WriteData_wb    <= wb_sel(MemtoReg_mem, ALUResult_mem, 32'h0, PC_4_mem);
               end
            end
            WAIT: begin
               RegWrite_wb     <= 1'b0;
               RegWriteAddr_wb <= '0;
               WriteData_wb    <= '0;
               // err beats ack; ack beats a timeout landing in the same cycle
               if (bus_err) begin
                  bus_req <= 1'b0;
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= DONE;
               end else if (bus_ack) begin
                  bus_req <= 1'b0;
                  rdata_q <= bus_rdata;
                  err_q   <= 1'b0;
                  state   <= DONE;
               end else if (wait_cnt == TO_LAST) begin
                  bus_req  <= 1'b0;
                  rdata_q  <= '0;
                  err_q    <= 1'b1;
                  wait_cnt <= wait_cnt + CW'(1);
                  state    <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            DONE: begin
               RegWrite_wb     <= RegWrite_mem & ~err_q;
               RegWriteAddr_wb <= RegWriteAddr_mem;
               WriteData_wb    <= wb_sel(MemtoReg_mem, ALUResult_mem, rdata_q, PC_4_mem);
               mem_fault       <= err_q;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT = 4): ALU pass-through, load, store,
// misaligned, bus error, timeout, ack at the timeout boundary, and async reset in WAIT.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead_mem, MemWrite_mem, RegWrite_mem;
   logic [1:0]  MemtoReg_mem;
   logic [4:0]  RegWriteAddr_mem;
   logic [31:0] ALUResult_mem, MemWriteData_mem, PC_4_mem, bus_rdata;
   logic        bus_ack, bus_err;
   logic        bus_req, bus_we, stall, RegWrite_wb, mem_fault;
   logic [31:0] bus_addr, bus_wdata, WriteData_wb;
   logic [4:0]  RegWriteAddr_wb;

   int n_checks = 0;
   int n_fail   = 0;

   int          n_req, n_stall;
   logic [31:0] seen_addr, seen_wdata;
   logic        seen_we;

   mem_access_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
      .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
      .RegWriteAddr_mem(RegWriteAddr_mem), .ALUResult_mem(ALUResult_mem),
      .MemWriteData_mem(MemWriteData_mem), .PC_4_mem(PC_4_mem),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .stall(stall), .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb),
      .WriteData_wb(WriteData_wb), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      MemRead_mem      = 1'b0;
      MemWrite_mem     = 1'b0;
      RegWrite_mem     = 1'b0;
      MemtoReg_mem     = 2'b00;
      RegWriteAddr_mem = 5'd0;
      ALUResult_mem    = 32'h0;
      MemWriteData_mem = 32'h0;
      PC_4_mem         = 32'h0;
   endtask

   // Presents an access (called just after a rising edge), counts stall and req cycles at the
   // falling edge, and answers on the ack_at-th req cycle (0 = never). Returns just after the
   // edge that leaves DONE, so the MEM/WB outputs are ready to check.
   task automatic do_mem(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at,
                         input logic give_ack, input logic give_err,
                         input logic [31:0] rdata);
      logic finished;
      MemRead_mem      = rd;
      MemWrite_mem     = wr;
      ALUResult_mem    = addr;
      MemWriteData_mem = wdata;
      n_req = 0; n_stall = 0;
      seen_addr = 32'h0; seen_wdata = 32'h0; seen_we = 1'b0;
      finished = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!stall) begin
            finished = 1'b1;
            break;
         end
         n_stall++;
         if (bus_req) begin
            n_req++;
            if (n_req == 1) begin
               seen_addr  = bus_addr;
               seen_wdata = bus_wdata;
               seen_we    = bus_we;
            end
            if (n_req == ack_at) begin
               bus_ack   = give_ack;
               bus_err   = give_err;
               bus_rdata = rdata;
            end
         end
         step();
         bus_ack = 1'b0;
         bus_err = 1'b0;
      end
      if (!finished) chk("access_bound", 32'(n_stall), 32'd0);
      step();
   endtask

   initial begin
      reset = 1'b1;
      set_nop();
      bus_rdata = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
      #1;
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_regwrite_wb", 32'(RegWrite_wb), 32'd0);
      chk("rst_wdata_wb", WriteData_wb, 32'h0);
      chk("rst_mem_fault", 32'(mem_fault), 32'd0);
      step();
      reset = 1'b0;

      // ALU op; a stray ack in IDLE must be ignored
      RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd5; ALUResult_mem = 32'h1234;
      MemtoReg_mem = 2'b00; bus_ack = 1'b1;
      @(negedge clk);
      chk("alu_stall", 32'(stall), 32'd0);
      step();
      bus_ack = 1'b0;
      chk("alu_regwrite", 32'(RegWrite_wb), 32'd1);
      chk("alu_addr", 32'(RegWriteAddr_wb), 32'd5);
      chk("alu_data", WriteData_wb, 32'h1234);
      chk("alu_no_req", 32'(bus_req), 32'd0);

      // MemtoReg = 10 selects PC+4, 11 selects ALU
      RegWriteAddr_mem = 5'd9; ALUResult_mem = 32'h55; PC_4_mem = 32'h404; MemtoReg_mem = 2'b10;
      step();
      chk("pc4_data", WriteData_wb, 32'h404);
      MemtoReg_mem = 2'b11;
      step();
      chk("sel11_data", WriteData_wb, 32'h55);

      // Load at 0x100, ack on third req cycle
      set_nop();
      RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd7; MemtoReg_mem = 2'b01;
      do_mem(1'b1, 1'b0, 32'h100, 32'h0, 3, 1'b1, 1'b0, 32'hDEADBEEF);
      chk("ld_req_cycles", 32'(n_req), 32'd3);
      chk("ld_stall_cycles", 32'(n_stall), 32'd4);
      chk("ld_bus_addr", seen_addr, 32'h100);
      chk("ld_bus_we", 32'(seen_we), 32'd0);
      chk("ld_data", WriteData_wb, 32'hDEADBEEF);
      chk("ld_regwrite", 32'(RegWrite_wb), 32'd1);
      chk("ld_wb_addr", 32'(RegWriteAddr_wb), 32'd7);
      chk("ld_no_fault", 32'(mem_fault), 32'd0);

      // Store with immediate ack
      set_nop();
      do_mem(1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 1, 1'b1, 1'b0, 32'h0);
      chk("st_req_cycles", 32'(n_req), 32'd1);
      chk("st_stall_cycles", 32'(n_stall), 32'd2);
      chk("st_bus_we", 32'(seen_we), 32'd1);
      chk("st_bus_addr", seen_addr, 32'h200);
      chk("st_bus_wdata", seen_wdata, 32'hA5A5A5A5);
      chk("st_no_fault", 32'(mem_fault), 32'd0);
      chk("st_regwrite", 32'(RegWrite_wb), 32'd0);

      // Misaligned load
      set_nop();
      RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd3; MemtoReg_mem = 2'b01;
      do_mem(1'b1, 1'b0, 32'h103, 32'h0, 1, 1'b1, 1'b0, 32'h0);
      chk("mis_stall_cycles", 32'(n_stall), 32'd0);
      chk("mis_req_cycles", 32'(n_req), 32'd0);
      chk("mis_regwrite", 32'(RegWrite_wb), 32'd0);
      chk("mis_fault", 32'(mem_fault), 32'd1);
      set_nop();
      step();
      chk("mis_fault_pulse", 32'(mem_fault), 32'd0);

      // ack and err together: treated as error
      RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd4; MemtoReg_mem = 2'b01;
      do_mem(1'b1, 1'b0, 32'h40, 32'h0, 2, 1'b1, 1'b1, 32'h12345678);
      chk("err_stall_cycles", 32'(n_stall), 32'd3);
      chk("err_regwrite", 32'(RegWrite_wb), 32'd0);
      chk("err_data", WriteData_wb, 32'h0);
      chk("err_fault", 32'(mem_fault), 32'd1);

      // No ack: timeout after 4 WAIT cycles
      do_mem(1'b1, 1'b0, 32'h80, 32'h0, 0, 1'b0, 1'b0, 32'h0);
      chk("to_req_cycles", 32'(n_req), 32'd4);
      chk("to_stall_cycles", 32'(n_stall), 32'd5);
      chk("to_bus_req", 32'(bus_req), 32'd0);
      chk("to_regwrite", 32'(RegWrite_wb), 32'd0);
      chk("to_fault", 32'(mem_fault), 32'd1);
      set_nop();
      step();
      chk("to_fault_pulse", 32'(mem_fault), 32'd0);
      chk("to_idle_stall", 32'(stall), 32'd0);

      // Ack in the cycle the counter hits TIMEOUT is accepted
      RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd11; MemtoReg_mem = 2'b01;
      do_mem(1'b1, 1'b0, 32'hC0, 32'h0, 4, 1'b1, 1'b0, 32'hCAFEF00D);
      chk("edge_req_cycles", 32'(n_req), 32'd4);
      chk("edge_regwrite", 32'(RegWrite_wb), 32'd1);
      chk("edge_data", WriteData_wb, 32'hCAFEF00D);
      chk("edge_no_fault", 32'(mem_fault), 32'd0);

      // Reset asserted mid-WAIT
      MemRead_mem = 1'b1; ALUResult_mem = 32'h300;
      step();
      chk("rw_req_before", 32'(bus_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rw_req_async", 32'(bus_req), 32'd0);
      chk("rw_stall_async", 32'(stall), 32'd0);
      chk("rw_regwrite_async", 32'(RegWrite_wb), 32'd0);
      chk("rw_data_async", WriteData_wb, 32'h0);
      step();
      reset = 1'b0;
      set_nop();
      RegWrite_mem = 1'b1; RegWriteAddr_mem = 5'd12; MemtoReg_mem = 2'b01;
      do_mem(1'b1, 1'b0, 32'h304, 32'h0, 2, 1'b1, 1'b0, 32'h0BADF00D);
      chk("rw_post_req", 32'(n_req), 32'd2);
      chk("rw_post_stall", 32'(n_stall), 32'd3);
      chk("rw_post_data", WriteData_wb, 32'h0BADF00D);
      chk("rw_post_addr", 32'(RegWriteAddr_wb), 32'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller sitting between the EX/MEM pipeline register and the MEM/WB register of the pipelined CPU. It consumes the EX/MEM outputs, runs each load or store as a req/ack transaction on the data bus, and stalls the pipeline until the transaction completes. It then selects the write-back value and registers the MEM/WB fields. Bus timeout and misaligned-address detection are included.

## Interface
- TIMEOUT, 255: maximum WAIT cycles without ack before the access is aborted.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- MemRead_mem, MemWrite_mem  in  1 each  access type from EX/MEM; both set is treated as a write.
- MemtoReg_mem  in  2  write-back select: 00 ALU, 01 memory, 10 PC+4, 11 ALU.
- RegWrite_mem  in  1  register write enable from EX/MEM.
- RegWriteAddr_mem  in  5  destination register.
- ALUResult_mem  in  32  address / ALU result.
- MemWriteData_mem  in  32  store data.
- PC_4_mem  in  32  PC+4.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  transaction complete.
- bus_err  in  1  transaction failed; ends the access like ack.
- bus_req  out  1  request, registered.
- bus_we  out  1  write strobe, registered.
- bus_addr, bus_wdata  out  32 each  registered address and data.
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- RegWrite_wb  out  1  MEM/WB write enable.
- RegWriteAddr_wb  out  5  MEM/WB destination.
- WriteData_wb  out  32  MEM/WB write-back value.
- mem_fault  out  1  one-cycle pulse on misalign, bus_err or timeout.

## Operation
- Access request: `access = MemRead_mem | MemWrite_mem`. An access is misaligned when `ALUResult_mem[1:0] != 0`.
- FSM states: IDLE, WAIT, DONE.
- IDLE, aligned access:
  - Load bus_addr, bus_wdata and bus_we (= MemWrite_mem); set bus_req to 1; go to WAIT.
  - stall = 1 (combinational).
- IDLE, misaligned access:
  - No bus cycle, stall = 0.
  - MEM/WB loads with RegWrite_wb = 0.
  - mem_fault pulses on the next cycle.
- IDLE, no access:
  - stall = 0.
  - MEM/WB loads RegWrite_mem, RegWriteAddr_mem, and WriteData_wb chosen by MemtoReg_mem.
- WAIT:
  - stall = 1 and the timeout counter increments.
  - On bus_ack or bus_err: bus_req goes to 0, rdata is captured (0 if err), go to DONE.
  - When the counter reaches TIMEOUT: bus_req goes to 0, data is forced to 0, error is flagged, go to DONE.
- DONE:
  - stall = 0 and MEM/WB loads from the still-held EX/MEM fields. For MemtoReg = 01 the captured data is used.
  - On error, RegWrite_wb is forced to 0 and mem_fault pulses.
  - Always return to IDLE; the access is never re-issued from DONE.
- Bubbles: while stall = 1, MEM/WB loads a bubble (RegWrite_wb = 0, addr 0, data 0).
- Stores: a store with RegWrite_mem = 1 is honoured as given. Gating that case is the decoder's job.
- Timeout counter: 8 bits wide minimum; cleared on entry to WAIT.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. An asserted reset in WAIT drops bus_req immediately.
- bus_req rises 1 cycle after the access appears in EX/MEM. bus_addr, bus_wdata and bus_we stay stable while bus_req = 1.
- Ack sampled k cycles after req rises (k ≥ 1): stall is high for k+1 cycles, then WB data is valid 1 cycle later.
- Fastest access: ack in the first WAIT cycle gives 2 stall cycles.
- Non-memory instructions: zero stall; 1-cycle EX/MEM → MEM/WB latency.
- Error priority: ack and err in the same cycle are treated as err. Ack in the same cycle the counter reaches TIMEOUT is accepted as ack.
- Ack or err while in IDLE or DONE is ignored.

## Test plan
- ALU op, MemtoReg = 00, ALUResult = 0x1234, RegWriteAddr = 5: no stall; next cycle RegWrite_wb = 1, addr 5, data 0x1234.
- Load at 0x100, ack after 3 cycles with rdata 0xDEADBEEF:
  - bus_req is high for 3 cycles and stall for 4.
  - WriteData_wb = 0xDEADBEEF in the cycle after DONE.
- Store 0xA5A5A5A5 to 0x200, immediate ack: bus_we = 1, bus_addr = 0x200, 2 stall cycles, mem_fault = 0.
- Load at 0x103: no bus_req, no stall, RegWrite_wb = 0, mem_fault pulses once.
- Load with no ack, TIMEOUT = 4:
  - Abort after 4 WAIT cycles; bus_req = 0.
  - mem_fault pulses, RegWrite_wb = 0, return to IDLE.
- Reset asserted mid-WAIT: bus_req, stall and all WB outputs go to 0 asynchronously; a new load after release proceeds normally.
